// File: rtl/rcv_ctrl_if.sv
// Signal bundle between the serial receive controller and its shift register,
// receive buffer and status logic.
interface rcv_ctrl_if;
  logic       serial_in;
  logic       stop_bit;
  logic       shift_strobe;
  logic       sbc_clear;
  logic       load_buffer;
  logic       framing_error;
  logic       receiving;
  logic [2:0] dbg_state;

  // Commands are single-cycle pulses with no back-pressure: the datapath acts
  // on every rising edge at which a pulse is high; levels are plain status.
  modport master (
    input  serial_in, stop_bit,
    output shift_strobe, sbc_clear, load_buffer, framing_error, receiving, dbg_state
  );

  modport slave (
    output serial_in, stop_bit,
    input  shift_strobe, sbc_clear, load_buffer, framing_error, receiving, dbg_state
  );
endinterface

// File: rtl/rcv_ctrl.sv
// Serial frame receive controller: detects a start bit, strobes nine mid-bit
// samples into a shift register, checks the stop bit and loads the buffer.
module rcv_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic     clk,
  input  logic     n_rst,
  rcv_ctrl_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [7:0] HALF_LAST = 8'(HALF_BIT - 1);
  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECEIVE   = 3'd2,
    STOP_CHK  = 3'd3,
    LOAD      = 3'd4
  } state_t;

  state_t     state_q, state_n;
  logic [7:0] cyc_q, cyc_n;
  logic [3:0] bit_q, bit_n;
  logic       prior_q;
  logic       armed_q;
  logic       strobe_q, strobe_n;
  logic       clear_q, clear_n;
  logic       load_q, load_n;
  logic       fe_q, fe_n;
  logic       recv_q, recv_n;
  logic       start_edge;

  // armed_q blocks a line that was already low at reset release from looking
  // like a fresh falling edge; a high sample must be seen first.
  assign start_edge = (state_q == IDLE) && !bus.serial_in && prior_q && armed_q;

  always_comb begin
    state_n  = state_q;
    cyc_n    = cyc_q;
    bit_n    = bit_q;
    strobe_n = 1'b0;
    clear_n  = 1'b0;
    load_n   = 1'b0;
    fe_n     = fe_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_n = START_CHK;
          cyc_n   = 8'd0;
          bit_n   = 4'd0;
          clear_n = 1'b1;
          fe_n    = 1'b0;
        end
      end
      START_CHK: begin
        if (cyc_q == HALF_LAST) begin
          state_n = bus.serial_in ? IDLE : RECEIVE;
          cyc_n   = 8'd1;
        end else begin
          cyc_n = cyc_q + 8'd1;
        end
      end
      RECEIVE: begin
        // Strobe is raised one edge early so it is high during the mid-bit edge.
        if (strobe_q && (bit_q == 4'd9)) begin
          state_n = STOP_CHK;
        end else if (cyc_q == BIT_LAST) begin
          strobe_n = 1'b1;
          cyc_n    = 8'd0;
          bit_n    = bit_q + 4'd1;
        end else begin
          cyc_n = cyc_q + 8'd1;
        end
      end
      STOP_CHK: begin
        if (bus.stop_bit) begin
          state_n = LOAD;
          load_n  = 1'b1;
        end else begin
          state_n = IDLE;
          fe_n    = 1'b1;
        end
      end
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    recv_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cyc_q    <= 8'd0;
      bit_q    <= 4'd0;
      prior_q  <= 1'b1;
      armed_q  <= 1'b0;
      strobe_q <= 1'b0;
      clear_q  <= 1'b0;
      load_q   <= 1'b0;
      fe_q     <= 1'b0;
      recv_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cyc_q    <= cyc_n;
      bit_q    <= bit_n;
      prior_q  <= bus.serial_in;
      if (bus.serial_in) armed_q <= 1'b1;
      strobe_q <= strobe_n;
      clear_q  <= clear_n;
      load_q   <= load_n;
      fe_q     <= fe_n;
      recv_q   <= recv_n;
    end
  end

  assign bus.shift_strobe  = strobe_q;
  assign bus.sbc_clear     = clear_q;
  assign bus.load_buffer   = load_q;
  assign bus.framing_error = fe_q;
  assign bus.receiving     = recv_q;
  assign bus.dbg_state     = state_q;

endmodule
